// File: rtl/nibble_serializer_16to4_if.sv
// Handshake bundle for the 16-to-4 nibble serializer:
// upstream word side plus downstream nibble side.
interface nibble_serializer_16to4_if;
  logic [15:0] inData;
  logic        inValid;
  logic        outReady;
  logic [3:0]  outData;
  logic [1:0]  outSel;
  logic        outValid;
  logic        outLast;
  logic        inDownReady;

  modport slave (
    input  inData,
    input  inValid,
    output outReady,
    output outData,
    output outSel,
    output outValid,
    output outLast,
    input  inDownReady
  );

  modport master (
    output inData,
    output inValid,
    input  outReady,
    input  outData,
    input  outSel,
    input  outValid,
    input  outLast,
    output inDownReady
  );
endinterface

// File: rtl/nibble_serializer_16to4.sv
// Zigbee TX serializer: one 16-bit word in, four
// nibbles out, slot index on outSel.
module nibble_serializer_16to4 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic inClk,
  input logic inRst,
  nibble_serializer_16to4_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_n;
  logic [15:0] hold_q, hold_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [1:0]  idx;
  logic        last;
  logic        acc;
  logic        hs;

  assign last = (state == SEND) && (cnt_q == 2'd3);

  // Ready opens on the final handshake so words chain without bubbles
  assign bus.outReady = !inRst &&
    ((state == IDLE) || (last && bus.inDownReady));

  assign bus.outValid = (state == SEND);
  assign bus.outLast  = last;
  assign bus.outSel   = cnt_q;

  assign idx = MSB_FIRST ? 2'd3 - cnt_q : cnt_q;
  assign bus.outData = hold_q[{idx, 2'b00} +: 4];

  assign acc = bus.inValid && bus.outReady;
  assign hs  = bus.outValid && bus.inDownReady;

  always_comb begin
    state_n = state;
    hold_n  = hold_q;
    cnt_n   = cnt_q;
    if (hs) begin
      cnt_n = cnt_q + 2'd1;
      if (cnt_q == 2'd3) state_n = IDLE;
    end
    if (acc) begin
      hold_n  = bus.inData;
      cnt_n   = 2'd0;
      state_n = SEND;
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state  <= IDLE;
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      hold_q <= hold_n;
      cnt_q  <= cnt_n;
    end
  end
endmodule

// File: tb/tb_nibble_serializer_16to4.sv
// Randomized + directed bench for nibble_serializer_16to4,
// both nibble orders checked against a queue model.
module tb_nibble_serializer_16to4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serializer_16to4_if bus_m ();
  nibble_serializer_16to4_if bus_l ();

  nibble_serializer_16to4 #(.MSB_FIRST(1'b1)) dut_m (
    .inClk(clk), .inRst(rst), .bus(bus_m.slave)
  );
  nibble_serializer_16to4 #(.MSB_FIRST(1'b0)) dut_l (
    .inClk(clk), .inRst(rst), .bus(bus_l.slave)
  );

  typedef struct {
    logic [3:0] m;
    logic [3:0] l;
    logic [1:0] sel;
  } nib_t;

  nib_t        q[$];
  logic [3:0]  logm[$];
  logic [3:0]  logl[$];
  logic [1:0]  logs[$];
  logic [15:0] wq[$];
  int          n_pass = 0;
  int          n_tot = 0;
  bit          fresh = 1'b0;
  bit          lb = 1'b0;
  int          lb_n = 0;
  logic [15:0] lb_m = '0;
  logic [15:0] lb_l = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clr_log();
    logm.delete(); logl.delete(); logs.delete();
  endtask

  function automatic logic [31:0] pack_m();
    logic [31:0] r = '0;
    foreach (logm[i]) r = (r << 4) | 32'(logm[i]);
    return r;
  endfunction

  function automatic logic [31:0] pack_l();
    logic [31:0] r = '0;
    foreach (logl[i]) r = (r << 4) | 32'(logl[i]);
    return r;
  endfunction

  function automatic logic [31:0] pack_s();
    logic [31:0] r = '0;
    foreach (logs[i]) r = (r << 2) | 32'(logs[i]);
    return r;
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [15:0] d, input logic dr,
                      input bit ck, output bit acc);
    bit   ev, er, hs;
    nib_t e;
    nib_t t;
    rst = r;
    bus_m.inValid = v;  bus_l.inValid = v;
    bus_m.inData  = d;  bus_l.inData  = d;
    bus_m.inDownReady = dr;
    bus_l.inDownReady = dr;
    @(negedge clk);
    ev = (q.size() != 0);
    er = !r && (q.size() == 0 || (q.size() == 1 && dr));
    if (ck) begin
      chk("valid_m", 32'(bus_m.outValid), 32'(ev));
      chk("valid_l", 32'(bus_l.outValid), 32'(ev));
      chk("ready_m", 32'(bus_m.outReady), 32'(er));
      chk("ready_l", 32'(bus_l.outReady), 32'(er));
      if (ev) begin
        e = q[0];
        chk("data_m", 32'(bus_m.outData), 32'(e.m));
        chk("data_l", 32'(bus_l.outData), 32'(e.l));
        chk("sel_m", 32'(bus_m.outSel), 32'(e.sel));
        chk("sel_l", 32'(bus_l.outSel), 32'(e.sel));
        chk("last_m", 32'(bus_m.outLast), 32'(e.sel == 2'd3));
        chk("last_l", 32'(bus_l.outLast), 32'(e.sel == 2'd3));
      end else begin
        chk("idle_sel", 32'(bus_m.outSel), 32'd0);
        chk("idle_last", 32'(bus_m.outLast | bus_l.outLast), 32'd0);
        if (fresh) begin
          chk("rst_data_m", 32'(bus_m.outData), 32'd0);
          chk("rst_data_l", 32'(bus_l.outData), 32'd0);
        end
      end
    end
    hs  = ev && dr;
    acc = v && er;
    if (lb && bus_m.outValid && dr) begin
      lb_m = lb_m | (16'(bus_m.outData) << (4 * (3 - int'(bus_m.outSel))));
      lb_l = lb_l | (16'(bus_l.outData) << (4 * int'(bus_l.outSel)));
      if (bus_m.outLast) begin
        if (wq.size() != 0) begin
          chk("loop_m", 32'(lb_m), 32'(wq[0]));
          chk("loop_l", 32'(lb_l), 32'(wq[0]));
          void'(wq.pop_front());
        end else chk("loop_extra", 32'(lb_m), 32'hFFFF_FFFF);
        lb_n++;
        lb_m = '0; lb_l = '0;
      end
    end
    if (hs) begin
      logm.push_back(q[0].m);
      logl.push_back(q[0].l);
      logs.push_back(q[0].sel);
    end
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (hs) void'(q.pop_front());
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          t.m   = 4'((d >> (12 - 4 * k)) & 16'hF);
          t.l   = 4'((d >> (4 * k)) & 16'hF);
          t.sel = 2'(k);
          q.push_back(t);
        end
        fresh = 1'b0;
        if (lb) wq.push_back(d);
      end
    end
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
    chk("drain", 32'(q.size()), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
  endtask

  initial begin
    bit a;
    bit got;
    logic [15:0] cur;
    int nw;
    logic v, dr;

    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, a);
    chk("rst_ready_hi", 32'(bus_m.outReady), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);

    clr_log();
    step(1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b1, a);
    chk("a5c3_acc", 32'(a), 32'd1);
    drain();
    chk("a5c3_msb", pack_m(), 32'h0000_A5C3);
    chk("a5c3_lsb", pack_l(), 32'h0000_3C5A);
    chk("a5c3_sel", pack_s(), 32'h0000_001B);

    clr_log();
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, a);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 1'b1, 16'h5678, 1'b1, 1'b1, a);
      got = a;
    end
    chk("b2b_acc", 32'(got), 32'd1);
    drain();
    chk("b2b_msb", pack_m(), 32'h1234_5678);
    chk("b2b_lsb", pack_l(), 32'h4321_8765);

    clr_log();
    step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, a);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
    repeat (3) step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, a);
    chk("bp_hold_data", 32'(bus_m.outData), 32'hE);
    chk("bp_hold_sel", 32'(bus_m.outSel), 32'd1);
    drain();
    chk("bp_msb", pack_m(), 32'h0000_BEEF);
    chk("bp_lsb", pack_l(), 32'h0000_FEEB);

    clr_log();
    step(1'b0, 1'b1, 16'hFACE, 1'b1, 1'b1, a);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
    chk("mid_sel2", 32'(bus_m.outSel), 32'd2);
    step(1'b1, 1'b1, 16'h9999, 1'b0, 1'b1, a);
    chk("mid_valid", 32'(bus_m.outValid), 32'd0);
    chk("mid_part", pack_m(), 32'h0000_00FA);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, a);
    clr_log();
    step(1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, a);
    drain();
    chk("post_msb", pack_m(), 32'h0000_0F0F);
    chk("post_lsb", pack_l(), 32'h0000_F0F0);
    chk("post_sel", pack_s(), 32'h0000_001B);

    lb = 1'b1;
    nw = 0;
    cur = 16'($urandom);
    for (int i = 0; i < 3000 && nw < 16; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      step(1'b0, v, cur, dr, 1'b1, a);
      if (a) begin
        nw++;
        cur = 16'($urandom);
      end
    end
    chk("rand_words", 32'(nw), 32'd16);
    drain();
    chk("loop_count", 32'(lb_n), 32'd16);
    chk("loop_left", 32'(wq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
